// File: rtl/approx_mult_pipe.sv
`default_nettype none
// ============================================================================
// Module   : approx_mult_pipe
// Brief    : 3-stage valid/ready unsigned multiplier with per-beat XOR
//            approximation of the low K columns and zero-operand skip.
// Revision : 1.0 - initial release
// ============================================================================
module approx_mult_pipe #(
    parameter int WIDTH = 8,
    parameter int MAX_K = WIDTH,
    parameter int KW    = (MAX_K < 1) ? 1 : $clog2(MAX_K + 1),
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic [KW-1:0]      in_k,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_p,
    output logic               out_zero,
    output logic [CNT_W-1:0]   gate_cnt
);

    localparam int            PW    = 2 * WIDTH;
    localparam logic [KW-1:0] K_MAX = KW'(MAX_K);

    logic              v1_q, v2_q, v3_q, v1_d, v2_d, v3_d;
    logic              z1_q, z2_q, z3_q, z1_d, z2_d, z3_d;
    logic [WIDTH-1:0]  a1_q, b1_q, a1_d, b1_d;
    logic [KW-1:0]     k1_q, k1_d;
    logic [PW-1:0]     low2_q, sum2_q, car2_q, low2_d, sum2_d, car2_d;
    logic [PW-1:0]     p3_q, p3_d;
    logic [CNT_W-1:0]  gate_cnt_q, gate_cnt_d;

    logic              adv1, adv2, adv3, accept, in_zero;
    logic [KW-1:0]     k_clamp;
    logic [PW-1:0]     low_w, sum_w, car_w;

    // Handshake: each stage drains into an empty or simultaneously draining successor.
    always_comb begin
        adv3     = v3_q && out_ready;
        adv2     = v2_q && (!v3_q || adv3);
        adv1     = v1_q && (!v2_q || adv2);
        in_ready = !v1_q || adv1;
        accept   = in_valid && in_ready;
        in_zero  = (in_a == '0) || (in_b == '0);
        k_clamp  = (in_k > K_MAX) ? K_MAX : in_k;
    end

    // Rows are split by a column mask: low columns XOR-fold, high columns go through a CSA chain.
    always_comb begin : compress
        logic [PW-1:0] hi_mask;
        logic [PW-1:0] row;
        logic [PW-1:0] hrow;
        logic [PW-1:0] maj;
        hi_mask = {PW{1'b1}} << k1_q;
        row     = '0;
        hrow    = '0;
        maj     = '0;
        low_w   = '0;
        sum_w   = '0;
        car_w   = '0;
        for (int j = 0; j < WIDTH; j++) begin
            row   = PW'(a1_q & {WIDTH{b1_q[j]}}) << j;
            low_w = low_w ^ (row & ~hi_mask);
            hrow  = row & hi_mask;
            maj   = (sum_w & car_w) | (sum_w & hrow) | (car_w & hrow);
            sum_w = sum_w ^ car_w ^ hrow;
            car_w = maj << 1;
        end
    end

    always_comb begin
        v1_d       = accept ? 1'b1 : (adv1 ? 1'b0 : v1_q);
        v2_d       = adv1   ? 1'b1 : (adv2 ? 1'b0 : v2_q);
        v3_d       = adv2   ? 1'b1 : (adv3 ? 1'b0 : v3_q);
        z1_d       = accept ? in_zero : z1_q;
        z2_d       = adv1   ? z1_q    : z2_q;
        z3_d       = adv2   ? z2_q    : z3_q;
        a1_d       = a1_q;
        b1_d       = b1_q;
        k1_d       = k1_q;
        low2_d     = low2_q;
        sum2_d     = sum2_q;
        car2_d     = car2_q;
        p3_d       = p3_q;
        gate_cnt_d = gate_cnt_q;
        // Zero-operand beats leave every data register untouched.
        if (accept && !in_zero) begin
            a1_d = in_a;
            b1_d = in_b;
            k1_d = k_clamp;
        end
        if (adv1 && !z1_q) begin
            low2_d = low_w;
            sum2_d = sum_w;
            car2_d = car_w;
        end
        if (adv2 && !z2_q) begin
            p3_d = low2_q + sum2_q + car2_q;
        end
        if (accept && in_zero && (gate_cnt_q != {CNT_W{1'b1}})) begin
            gate_cnt_d = gate_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q       <= 1'b0;
            v2_q       <= 1'b0;
            v3_q       <= 1'b0;
            z1_q       <= 1'b0;
            z2_q       <= 1'b0;
            z3_q       <= 1'b0;
            a1_q       <= '0;
            b1_q       <= '0;
            k1_q       <= '0;
            low2_q     <= '0;
            sum2_q     <= '0;
            car2_q     <= '0;
            p3_q       <= '0;
            gate_cnt_q <= '0;
        end else begin
            v1_q       <= v1_d;
            v2_q       <= v2_d;
            v3_q       <= v3_d;
            z1_q       <= z1_d;
            z2_q       <= z2_d;
            z3_q       <= z3_d;
            a1_q       <= a1_d;
            b1_q       <= b1_d;
            k1_q       <= k1_d;
            low2_q     <= low2_d;
            sum2_q     <= sum2_d;
            car2_q     <= car2_d;
            p3_q       <= p3_d;
            gate_cnt_q <= gate_cnt_d;
        end
    end

    assign out_valid = v3_q;
    assign out_p     = z3_q ? '0 : p3_q;
    assign out_zero  = z3_q;
    assign gate_cnt  = gate_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_approx_mult_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_approx_mult_pipe
// Brief    : Self-checking bench for approx_mult_pipe (WIDTH=8, MAX_K=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_approx_mult_pipe;

    localparam int WIDTH = 8;
    localparam int MAX_K = 8;
    localparam int KW    = 4;
    localparam int CNT_W = 16;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_a;
    logic [WIDTH-1:0]   in_b;
    logic [KW-1:0]      in_k;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] out_p;
    logic               out_zero;
    logic [CNT_W-1:0]   gate_cnt;

    approx_mult_pipe #(.WIDTH(WIDTH), .MAX_K(MAX_K), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_k(in_k),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_p(out_p), .out_zero(out_zero), .gate_cnt(gate_cnt)
    );

    always #5 clk = ~clk;

    int          nvec = 0;
    int          nerr = 0;
    int          cyc  = 0;
    int          zcount = 0;
    bit          acc;
    bit          lat_on;
    logic [15:0] q_p[$];
    bit          q_z[$];
    int          q_c[$];

    // Column-count reference: parity below k, full weighted count at or above k.
    function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b, input logic [3:0] k);
        int kk;
        int cnt;
        longint total;
        kk    = (int'(k) > MAX_K) ? MAX_K : int'(k);
        total = 0;
        for (int c = 0; c < 2*WIDTH - 1; c++) begin
            cnt = 0;
            for (int i = 0; i < WIDTH; i++) begin
                if ((c - i) >= 0 && (c - i) < WIDTH)
                    cnt += (a[i] & b[c-i]) ? 1 : 0;
            end
            if (c < kk) total += longint'(cnt % 2) << c;
            else        total += longint'(cnt) << c;
        end
        return total[15:0];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        int c0;
        logic [15:0] ep;
        bit ez;
        @(negedge clk);
        acc = in_valid && in_ready;
        if (out_valid && out_ready) begin
            if (q_p.size() == 0) begin
                chk("spurious_out", out_valid, 0);
            end else begin
                ep = q_p.pop_front();
                ez = q_z.pop_front();
                c0 = q_c.pop_front();
                chk("out_p", out_p, ep);
                chk("out_zero", out_zero, ez);
                if (lat_on) chk("latency", cyc - c0, 3);
            end
        end
        if (acc) begin
            q_p.push_back(model(in_a, in_b, in_k));
            q_z.push_back(in_a == 0 || in_b == 0);
            q_c.push_back(cyc);
            if (in_a == 0 || in_b == 0) zcount++;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [3:0] k);
        bit done;
        done     = 0;
        in_a     = a;
        in_b     = b;
        in_k     = k;
        in_valid = 1'b1;
        for (int n = 0; n < 20 && !done; n++) begin
            tick();
            if (acc) done = 1;
        end
        chk("send_timeout", done, 1);
    endtask

    task automatic drain();
        in_valid = 1'b0;
        for (int n = 0; n < 40 && q_p.size() != 0; n++) tick();
        chk("drain_left", q_p.size(), 0);
    endtask

    logic [15:0] snap_low, snap_sum, snap_car, snap_p3, stall_p;
    logic [7:0]  sa[5];
    logic [7:0]  sb[5];
    int          idx, nacc;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_k      = '0;
        out_ready = 1'b1;
        lat_on    = 1'b1;
        #3;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_p", out_p, 0);
        chk("rst_out_zero", out_zero, 0);
        chk("rst_gate_cnt", gate_cnt, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("idle_in_ready", in_ready, 1);

        // Exact products back to back, latency 3.
        chk("model_200x150", model(200, 150, 0), 30000);
        send(200, 150, 0);
        send(255, 255, 0);
        send(1, 1, 0);
        drain();

        chk("model_7x7_k3", model(7, 7, 3), 37);
        chk("model_15x15_k4", model(15, 15, 4), 181);
        send(7, 7, 3);
        send(15, 15, 4);
        send(7, 7, 0);
        send(15, 15, 0);
        drain();

        // Zero-operand skip leaves downstream data registers untouched.
        chk("gate_cnt_pre", gate_cnt, 0);
        snap_low = dut.low2_q;
        snap_sum = dut.sum2_q;
        snap_car = dut.car2_q;
        snap_p3  = dut.p3_q;
        send(0, 99, 2);
        drain();
        chk("gate_cnt_post", gate_cnt, 1);
        chk("hold_low2", dut.low2_q, snap_low);
        chk("hold_sum2", dut.sum2_q, snap_sum);
        chk("hold_car2", dut.car2_q, snap_car);
        chk("hold_p3", dut.p3_q, snap_p3);
        send(3, 5, 0);
        drain();

        // Backpressure: five beats offered into a stalled pipe.
        lat_on    = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            sa[i] = 8'($urandom_range(1, 255));
            sb[i] = 8'($urandom_range(1, 255));
        end
        idx  = 0;
        nacc = 0;
        for (int n = 0; n < 6; n++) begin
            in_a = sa[idx]; in_b = sb[idx]; in_k = 4'(idx); in_valid = 1'b1;
            tick();
            if (acc) begin idx++; nacc++; end
        end
        chk("stall_accepted", nacc, 3);
        chk("stall_in_ready", in_ready, 0);
        stall_p = out_p;
        tick();
        tick();
        chk("stall_p_stable", out_p, stall_p);
        chk("stall_out_valid", out_valid, 1);
        out_ready = 1'b1;
        #1;
        chk("ready_same_cycle", in_ready, 1);
        while (idx < 5) begin
            send(sa[idx], sb[idx], 4'(idx));
            idx++;
        end
        drain();

        // Depth above MAX_K clamps to MAX_K.
        chk("model_clamp", model(8'hB7, 8'hDE, 4'(MAX_K + 1)), model(8'hB7, 8'hDE, 4'(MAX_K)));
        send(8'hB7, 8'hDE, 4'(MAX_K + 1));
        send(8'hB7, 8'hDE, 4'(MAX_K));
        drain();

        // Randomized traffic with random backpressure.
        for (int n = 0; n < 400; n++) begin
            in_valid  = ($urandom % 4) != 0;
            in_a      = (($urandom % 8) == 0) ? 8'd0 : 8'($urandom);
            in_b      = (($urandom % 8) == 0) ? 8'd0 : 8'($urandom);
            in_k      = 4'($urandom);
            out_ready = ($urandom % 3) != 0;
            tick();
        end
        out_ready = 1'b1;
        drain();
        chk("gate_cnt_total", gate_cnt, zcount);

        // Reset with two beats in flight.
        lat_on = 1'b1;
        send(8'h12, 8'h34, 0);
        send(0, 5, 0);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_gate_cnt", gate_cnt, 0);
        q_p.delete();
        q_z.delete();
        q_c.delete();
        zcount = 0;
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (5) tick();
        send(9, 9, 0);
        drain();
        chk("gate_cnt_final", gate_cnt, zcount);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
`default_nettype wire
